// File: rtl/instr_decode_unit.sv
// Instruction buffer and decoder: a DEPTH-entry FIFO feeding a registered
// valid/ready decode stage with address/mode fields, S/V enables and a one-hot op.
module instr_decode_unit #(
  parameter int ADDR_W = 5,
  parameter int AM_W   = 2,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 8,
  parameter logic [(1<<OP_W)-1:0] OP_EN = '1,
  localparam int INSTR_W = 1 + OP_W + 2*AM_W + 2*ADDR_W,
  localparam int NOPS    = 1 << OP_W,
  localparam int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  W_addr,
  output logic [ADDR_W-1:0]  R_addr,
  output logic [AM_W-1:0]    W_am,
  output logic [AM_W-1:0]    R_am,
  output logic               S_en,
  output logic               V_en,
  output logic [NOPS-1:0]    op_onehot,
  output logic               illegal,
  output logic               buf_empty,
  output logic               buf_full,
  output logic [CNT_W-1:0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic push;
  logic pop;

  assign buf_full   = (count == CNT_W'(DEPTH));
  assign buf_empty  = (count == '0);
  assign in_ready   = !buf_full;
  assign fifo_count = count;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign push = in_valid && !buf_full;
  assign pop  = !buf_empty && (!out_valid || out_ready);

  // Head entry field extraction; W_addr sits at the LSBs.
  logic [INSTR_W-1:0] head;
  logic [OP_W-1:0]    head_op;
  logic [NOPS-1:0]    dec_onehot;
  logic               dec_legal;

  assign head      = mem[rd_ptr];
  assign head_op   = head[2*ADDR_W+2*AM_W +: OP_W];
  assign dec_legal = OP_EN[head_op];

  always_comb begin
    dec_onehot = '0;
    if (dec_legal) begin
      dec_onehot[head_op] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output stage holds its fields after out_valid drops; only reset/flush clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      W_addr    <= '0;
      R_addr    <= '0;
      W_am      <= '0;
      R_am      <= '0;
      S_en      <= 1'b0;
      V_en      <= 1'b0;
      op_onehot <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      W_addr    <= '0;
      R_addr    <= '0;
      W_am      <= '0;
      R_am      <= '0;
      S_en      <= 1'b0;
      V_en      <= 1'b0;
      op_onehot <= '0;
      illegal   <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      W_addr    <= head[0 +: ADDR_W];
      R_addr    <= head[ADDR_W +: ADDR_W];
      W_am      <= head[2*ADDR_W +: AM_W];
      R_am      <= head[2*ADDR_W+AM_W +: AM_W];
      S_en      <= head[INSTR_W-1];
      V_en      <= !head[INSTR_W-1];
      op_onehot <= dec_onehot;
      illegal   <= !dec_legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode_unit.sv
// Self-checking bench for instr_decode_unit: decode table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_instr_decode_unit;

  localparam logic [7:0] OP_EN_TB = 8'h7F;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  W_addr, R_addr;
  logic [1:0]  W_am, R_am;
  logic        S_en, V_en;
  logic [7:0]  op_onehot;
  logic        illegal;
  logic        buf_empty, buf_full;
  logic [3:0]  fifo_count;

  always #5 clk = ~clk;

  instr_decode_unit #(.ADDR_W(5), .AM_W(2), .OP_W(3), .DEPTH(DEPTH), .OP_EN(OP_EN_TB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .W_addr(W_addr), .R_addr(R_addr), .W_am(W_am), .R_am(R_am),
    .S_en(S_en), .V_en(V_en), .op_onehot(op_onehot), .illegal(illegal),
    .buf_empty(buf_empty), .buf_full(buf_full), .fifo_count(fifo_count)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending instructions plus the visible output record.
  logic [17:0] q[$];
  logic        m_ov;
  logic [4:0]  m_wa, m_ra;
  logic [1:0]  m_wam, m_ram;
  logic        m_s, m_v, m_ill;
  logic [7:0]  m_oh;

  task automatic model_clear();
    m_ov = 0; m_wa = 0; m_ra = 0; m_wam = 0; m_ram = 0;
    m_s = 0; m_v = 0; m_ill = 0; m_oh = 0;
  endtask

  task automatic model_step(input logic iv, input logic [17:0] ins, input logic ordy, input logic fl);
    bit do_pop, do_push;
    logic [17:0] h;
    logic [2:0] opc;
    if (fl) begin
      q.delete();
      model_clear();
      return;
    end
    do_pop  = (q.size() > 0) && (!m_ov || ordy);
    do_push = iv && (q.size() < DEPTH);
    if (do_pop) begin
      h     = q.pop_front();
      opc   = h[16:14];
      m_ov  = 1;
      m_s   = h[17];
      m_v   = !h[17];
      m_ram = h[13:12];
      m_wam = h[11:10];
      m_ra  = h[9:5];
      m_wa  = h[4:0];
      m_ill = !OP_EN_TB[opc];
      m_oh  = m_ill ? 8'h00 : (8'd1 << opc);
    end else if (ordy) begin
      m_ov = 0;
    end
    if (do_push) q.push_back(ins);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("status", {60'd0, in_ready, buf_empty, buf_full, fifo_count[0]} | {56'd0, fifo_count, 4'd0} ,
          {60'd0, 1'(n < DEPTH), 1'(n == 0), 1'(n == DEPTH), 1'(n % 2)} | {56'd0, 4'(n), 4'd0});
    check("outputs", {40'd0, out_valid, S_en, V_en, illegal, op_onehot, R_am, W_am, R_addr, W_addr},
          {40'd0, m_ov, m_s, m_v, m_ill, m_oh, m_ram, m_wam, m_ra, m_wa});
  endtask

  task automatic step(input logic iv, input logic [17:0] ins, input logic ordy, input logic fl);
    in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
    @(posedge clk);
    model_step(iv, ins, ordy, fl);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic [17:0] instr;
    logic [7:0]  oh;
    logic        ill, s, v;
    logic [1:0]  ram, wam;
    logic [4:0]  ra, wa;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{18'b1_010_01_10_00011_00101, 8'h04, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 5'd3,  5'd5};
    tbl[1] = '{18'b0_111_11_00_11111_00000, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 2'd0, 5'd31, 5'd0};
    tbl[2] = '{18'b0_000_00_11_10101_01010, 8'h01, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 5'd21, 5'd10};
    tbl[3] = '{18'b1_101_10_01_00001_11110, 8'h20, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 5'd1,  5'd30};

    rst_n = 0; flush = 0; in_valid = 0; in_instr = '0; out_ready = 0;
    q.delete(); model_clear();
    repeat (2) @(negedge clk);
    check("reset_empty", {62'd0, buf_empty, in_ready}, 64'd3);
    check("reset_cnt", {60'd0, fifo_count}, 64'd0);
    rst_n = 1;
    check_all();

    // Decode table: each entry visible exactly one edge after acceptance.
    foreach (tbl[i]) begin
      step(0, '0, 1, 1);
      step(1, tbl[i].instr, 1, 0);
      check("latency_pre", {63'd0, out_valid}, 64'd0);
      step(0, '0, 1, 0);
      check($sformatf("decode%0d", i),
            {40'd0, out_valid, S_en, V_en, illegal, op_onehot, R_am, W_am, R_addr, W_addr},
            {40'd0, 1'b1, tbl[i].s, tbl[i].v, tbl[i].ill, tbl[i].oh, tbl[i].ram, tbl[i].wam, tbl[i].ra, tbl[i].wa});
    end

    // Fill with out_ready low: one in output stage, eight in FIFO, rest refused.
    step(0, '0, 1, 1);
    for (int k = 0; k < 11; k++) step(1, 18'($urandom), 0, 0);
    check("full_flags", {59'd0, buf_full, in_ready, fifo_count}, {59'd0, 1'b1, 1'b0, 4'd8});
    step(1, 18'($urandom), 1, 0);
    check("full_pop_no_push", {60'd0, fifo_count}, 64'd7);
    for (int k = 0; k < 12; k++) step(0, '0, 1, 0);
    check("drained", {62'd0, buf_empty, out_valid}, 64'd2);

    // Streaming: occupancy never grows past one.
    for (int k = 0; k < 20; k++) begin
      step(1, 18'($urandom), 1, 0);
      check("stream_cnt", {63'd0, 1'(fifo_count <= 4'd1)}, 64'd1);
    end
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Flush with four queued and a push in the same cycle.
    for (int k = 0; k < 5; k++) step(1, 18'($urandom), 0, 0);
    check("pre_flush_cnt", {60'd0, fifo_count}, 64'd4);
    step(1, 18'h2AAAA, 0, 1);
    check("flush", {59'd0, out_valid, fifo_count}, 64'd0);
    step(0, '0, 1, 0);
    check("flush_dropped", {59'd0, out_valid, fifo_count}, 64'd0);

    // Asynchronous reset mid-burst with five entries queued.
    for (int k = 0; k < 6; k++) step(1, 18'($urandom), 0, 0);
    #2 rst_n = 0;
    #1;
    check("async_rst", {48'd0, out_valid, buf_empty, buf_full, fifo_count, op_onehot, illegal},
          {48'd0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0});
    check("async_rst_fields", {46'd0, W_addr, R_addr, W_am, R_am, S_en, V_en}, 64'd0);
    q.delete(); model_clear();
    @(negedge clk);
    rst_n = 1;
    check_all();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 9) < 7), 18'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
